pid_ahb_master: RTL

- AHB-Lite initiator that issues single 32-bit transfers toward the PID accelerator slave register block, or any AHB-Lite slave at BASE_ADDR.
- Local clients (test sequencer, control CPU shim) queue read/write commands through a valid/ready port.
- Commands are buffered in a small FIFO, converted into pipelined NONSEQ transfers that honour HREADY wait states and two-cycle ERROR responses, and completions are returned on a response port.

---
 rtl/pid_ahb_pkg.sv | 42 ++++
 rtl/pid_ahb_cmd_fifo.sv | 60 ++++++
 rtl/pid_ahb_master.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pid_ahb_pkg.sv
// Shared AHB-Lite encodings, PID register map and command format for the
// PID accelerator bus initiator.
package pid_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  localparam logic [11:0] REG_INITN  = 12'h000;
  localparam logic [11:0] REG_COEFF0 = 12'h004;
  localparam logic [11:0] REG_COEFF1 = 12'h008;
  localparam logic [11:0] REG_COEFF2 = 12'h00C;
  localparam logic [11:0] REG_COEFF3 = 12'h010;
  localparam logic [11:0] REG_COEFF4 = 12'h014;
  localparam logic [11:0] REG_COEFF5 = 12'h018;
  localparam logic [11:0] REG_DIN0   = 12'h01C;
  localparam logic [11:0] REG_DIN1   = 12'h020;

  typedef struct packed {
    logic        write;
    logic [11:0] addr;
    logic [31:0] wdata;
  } pid_cmd_t;

  localparam int CMD_W = $bits(pid_cmd_t);

  // Word-aligned bus address: byte-lane bits of the offset are dropped.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [11:0] offset);
    return base | {20'h0_0000, offset[11:2], 2'b00};
  endfunction

endpackage

// File: rtl/pid_ahb_cmd_fifo.sv
// Command FIFO between the client port and the AHB address phase; the head
// entry is visible combinationally so it can drive the address phase.
module pid_ahb_cmd_fifo
  import pid_ahb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             push,
  input  logic [CMD_W-1:0] push_data,
  input  logic             pop,
  output logic [CMD_W-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [CMD_W-1:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_s;
  logic             pop_s;

  assign full   = (count_r == FULL_CNT);
  assign empty  = (count_r == {CW{1'b0}});
  assign push_s = push & ~full;
  assign pop_s  = pop & ~empty;
  assign head   = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {CMD_W{1'b0}};
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/pid_ahb_master.sv
// AHB-Lite initiator issuing single pipelined word transfers from a queued
// command stream, with wait-state and two-cycle ERROR handling.
module pid_ahb_master
  import pid_ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [11:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic [1:0]  HRESP
);

  pid_cmd_t         push_cmd_s;
  pid_cmd_t         head_s;
  logic [CMD_W-1:0] head_bits_s;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic             nonseq_s;
  logic             err_s;

  logic             ready_en_r;
  logic             cancel_r;
  logic             dp_valid_r;
  logic             dp_write_r;
  logic [31:0]      dp_wdata_r;
  logic             rsp_valid_r;
  logic             rsp_err_r;
  logic [31:0]      rsp_rdata_r;

  assign push_cmd_s = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  assign head_s     = pid_cmd_t'(head_bits_s);

  // ready_en_r keeps the port closed until the first edge after reset.
  assign cmd_ready = ready_en_r & ~full_s;
  assign push_s    = cmd_valid & cmd_ready;
  assign nonseq_s  = ~empty_s & ~cancel_r;
  assign pop_s     = nonseq_s & HREADY;
  assign err_s     = (HRESP == HRESP_ERROR);

  pid_ahb_cmd_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_cmd_fifo (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .push     (push_s),
    .push_data(push_cmd_s),
    .pop      (pop_s),
    .head     (head_bits_s),
    .full     (full_s),
    .empty    (empty_s)
  );

  // Address phase follows the FIFO head; it only advances on a pop.
  always_comb begin
    HTRANS = HTRANS_IDLE;
    HADDR  = BASE_ADDR;
    HWRITE = 1'b0;
    if (!empty_s) begin
      HADDR  = word_addr(BASE_ADDR, head_s.addr);
      HWRITE = head_s.write;
      if (nonseq_s) begin
        HTRANS = HTRANS_NONSEQ;
      end else begin
        HTRANS = HTRANS_IDLE;
      end
    end else begin
      HTRANS = HTRANS_IDLE;
      HADDR  = BASE_ADDR;
      HWRITE = 1'b0;
    end
  end

  assign HSIZE     = HSIZE_WORD;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DATA;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = dp_wdata_r;

  // Data-phase register and error-cancel flag.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ready_en_r <= 1'b0;
      cancel_r   <= 1'b0;
      dp_valid_r <= 1'b0;
      dp_write_r <= 1'b0;
      dp_wdata_r <= 32'h0000_0000;
    end else begin
      ready_en_r <= 1'b1;
      // First ERROR cycle withdraws the pending address phase for one cycle.
      if (dp_valid_r && err_s && !HREADY) begin
        cancel_r <= 1'b1;
      end else if (HREADY) begin
        cancel_r <= 1'b0;
      end else begin
        cancel_r <= cancel_r;
      end
      if (HREADY) begin
        dp_valid_r <= pop_s;
        dp_write_r <= pop_s & head_s.write;
        dp_wdata_r <= (pop_s && head_s.write) ? head_s.wdata : 32'h0000_0000;
      end else begin
        dp_valid_r <= dp_valid_r;
        dp_write_r <= dp_write_r;
        dp_wdata_r <= dp_wdata_r;
      end
    end
  end

  // Completion pulse, one cycle after the data phase ends.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
    end else if (dp_valid_r && HREADY) begin
      rsp_valid_r <= 1'b1;
      rsp_err_r   <= err_s;
      rsp_rdata_r <= dp_write_r ? 32'h0000_0000 : HRDATA;
    end else begin
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;

endmodule
